// File: rtl/alu_pkt_initiator.sv
// Packet initiator for a byte-serial ALU: sends a 4-byte header and operand words over a tx
// byte stream, then collects a 4-byte big-endian result from the rx stream.
module alu_pkt_initiator #(
    parameter int unsigned datawidth_p = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [7:0]             cmd_opcode_i,
    input  logic [15:0]            cmd_len_i,
    input  logic [31:0]            op_data_i,
    input  logic                   op_valid_i,
    output logic                   op_ready_o,
    output logic [datawidth_p-1:0] tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    input  logic [datawidth_p-1:0] rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    output logic [31:0]            rsp_data_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   busy_o
);

    typedef enum logic [2:0] {
        StIdle, StHdrOp, StHdrRsv, StHdrLenL, StHdrLenM, StOperand, StRspCollect, StRspOut
    } state_e;

    state_e                 state_q, state_d;
    logic [15:0]            len_q, len_d;
    logic [15:0]            words_q, words_d;
    logic [31:0]            buf_q, buf_d;
    logic                   buf_full_q, buf_full_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [1:0]             rx_cnt_q, rx_cnt_d;
    logic [datawidth_p-1:0] tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [31:0]            rsp_data_q, rsp_data_d;
    logic                   rsp_valid_q, rsp_valid_d;
    // Keeps cmd_ready_o low while reset is held even though the state is already StIdle.
    logic                   rdy_en_q;

    logic cmd_xfer, op_xfer, tx_xfer, rx_xfer, rsp_xfer;

    assign cmd_ready_o = (state_q == StIdle) && rdy_en_q;
    assign op_ready_o  = (state_q == StOperand) && !buf_full_q;
    assign rx_ready_o  = (state_q == StRspCollect);
    assign busy_o      = (state_q != StIdle);
    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_valid_o = rsp_valid_q;

    assign cmd_xfer = cmd_valid_i && cmd_ready_o;
    assign op_xfer  = op_valid_i && op_ready_o;
    assign tx_xfer  = tx_valid_q && tx_ready_i;
    assign rx_xfer  = rx_valid_i && rx_ready_o;
    assign rsp_xfer = rsp_valid_q && rsp_ready_i;

    // Next-state logic: header sequencing, operand serialisation and response assembly.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        words_d     = words_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        byte_idx_d  = byte_idx_q;
        rx_cnt_d    = rx_cnt_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_xfer) begin
                    len_d      = cmd_len_i;
                    // Residual bytes beyond whole words are never sent.
                    words_d    = (cmd_len_i >= 16'd4) ? ((cmd_len_i - 16'd4) >> 2) : 16'd0;
                    tx_data_d  = cmd_opcode_i;
                    tx_valid_d = 1'b1;
                    rsp_data_d = '0;
                    rx_cnt_d   = '0;
                    buf_full_d = 1'b0;
                    state_d    = StHdrOp;
                end
            end
            StHdrOp: begin
                if (tx_xfer) begin
                    tx_data_d = '0;
                    state_d   = StHdrRsv;
                end
            end
            StHdrRsv: begin
                if (tx_xfer) begin
                    tx_data_d = len_q[7:0];
                    state_d   = StHdrLenL;
                end
            end
            StHdrLenL: begin
                if (tx_xfer) begin
                    tx_data_d = len_q[15:8];
                    state_d   = StHdrLenM;
                end
            end
            StHdrLenM: begin
                if (tx_xfer) begin
                    tx_valid_d = 1'b0;
                    state_d    = (words_q == 16'd0) ? StRspCollect : StOperand;
                end
            end
            StOperand: begin
                // op_xfer and tx_xfer are exclusive: tx is only valid while the buffer is full.
                if (op_xfer) begin
                    buf_d      = op_data_i;
                    buf_full_d = 1'b1;
                    byte_idx_d = 2'd0;
                    tx_data_d  = op_data_i[7:0];
                    tx_valid_d = 1'b1;
                    words_d    = words_q - 16'd1;
                end else if (tx_xfer) begin
                    if (byte_idx_q == 2'd3) begin
                        buf_full_d = 1'b0;
                        tx_valid_d = 1'b0;
                        if (words_q == 16'd0) begin
                            state_d = StRspCollect;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_data_d  = buf_q[{byte_idx_q + 2'd1, 3'b000} +: 8];
                    end
                end
            end
            StRspCollect: begin
                if (rx_xfer) begin
                    rsp_data_d = {rsp_data_q[23:0], rx_data_i};
                    rx_cnt_d   = rx_cnt_q + 2'd1;
                    if (rx_cnt_q == 2'd3) begin
                        rsp_valid_d = 1'b1;
                        state_d     = StRspOut;
                    end
                end
            end
            StRspOut: begin
                if (rsp_xfer) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, cleared asynchronously so a reset aborts any packet.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            len_q       <= '0;
            words_q     <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            byte_idx_q  <= '0;
            rx_cnt_q    <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            words_q     <= words_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            byte_idx_q  <= byte_idx_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rdy_en_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_pkt_initiator.sv
// Self-checking bench: table of packets plus hand-written stall, short-length, early-rx and
// mid-packet reset sequences. tx bytes and responses are checked against scoreboard queues.
module tb_alu_pkt_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [15:0] cmd_len;
    logic [31:0] op_data;
    logic        op_valid, op_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;
    logic [31:0] rsp_data;
    logic        rsp_valid, rsp_ready;
    logic        busy;

    alu_pkt_initiator #(.datawidth_p(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_opcode_i(cmd_opcode), .cmd_len_i(cmd_len),
        .op_data_i(op_data), .op_valid_i(op_valid), .op_ready_o(op_ready),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .rsp_data_o(rsp_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] len;
        int          nw;    // expected operand words sent
        logic [31:0] base;  // word k = base + k*step
        logic [31:0] step;
        logic [31:0] rx;    // response word returned on rx
    } vec_t;

    vec_t        tbl[5];
    logic [7:0]  tx_exp[$];
    logic [31:0] rsp_exp[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          op_seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %h expected nothing at %0t", nm, act, $time);
    endtask

    // Scoreboard monitor, sampled on the falling edge away from DUT updates.
    always @(negedge clk) begin
        if (op_ready) op_seen = 1'b1;
        if (tx_valid && tx_ready) begin
            if (tx_exp.size() == 0) fail_now("tx_extra", {24'd0, tx_data});
            else chk("tx_byte", {24'd0, tx_data}, {24'd0, tx_exp.pop_front()});
        end
        if (rsp_valid && rsp_ready) begin
            if (rsp_exp.size() == 0) fail_now("rsp_extra", rsp_data);
            else chk("rsp_data", rsp_data, rsp_exp.pop_front());
        end
    end

    function automatic logic [31:0] word_of(input vec_t v, input int k);
        return v.base + v.step * k;
    endfunction

    task automatic push_exp(input vec_t v);
        logic [31:0] w;
        tx_exp.push_back(v.op);
        tx_exp.push_back(8'h00);
        tx_exp.push_back(v.len[7:0]);
        tx_exp.push_back(v.len[15:8]);
        for (int k = 0; k < v.nw; k++) begin
            w = word_of(v, k);
            for (int b = 0; b < 4; b++) tx_exp.push_back(w[8*b +: 8]);
        end
        rsp_exp.push_back(v.rx);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [15:0] len);
        int k;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_len = len;
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        if (k == 1000) fail_now("cmd_timeout", 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Must follow send_cmd directly: header bytes on four consecutive cycles.
    task automatic hdr_check(input logic [7:0] op, input logic [15:0] len);
        logic [7:0] hb[4];
        hb[0] = op; hb[1] = 8'h00; hb[2] = len[7:0]; hb[3] = len[15:8];
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("hdr_valid", {31'd0, tx_valid}, 1);
            chk("hdr_byte", {24'd0, tx_data}, {24'd0, hb[b]});
        end
    endtask

    task automatic send_op(input logic [31:0] w);
        int k;
        @(posedge clk); #1;
        op_valid = 1'b1; op_data = w;
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (op_ready) break;
        end
        if (k == 1000) fail_now("op_timeout", w);
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic send_rx_word(input logic [31:0] w);
        int k;
        for (int b = 0; b < 4; b++) begin
            @(posedge clk); #1;
            rx_valid = 1'b1; rx_data = w[31-8*b -: 8];
            for (k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (rx_ready) break;
            end
            if (k == 1000) fail_now("rx_timeout", w);
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic take_rsp();
        int k;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        if (k == 1000) fail_now("rsp_timeout", 0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 1);
    endtask

    task automatic run_pkt(input vec_t v);
        push_exp(v);
        send_cmd(v.op, v.len);
        chk("busy", {31'd0, busy}, 1);
        hdr_check(v.op, v.len);
        if (v.nw == 0) begin
            @(negedge clk);
            chk("rx_ready_after_hdr", {31'd0, rx_ready}, 1);
        end
        for (int k = 0; k < v.nw; k++) send_op(word_of(v, k));
        send_rx_word(v.rx);
        take_rsp();
        chk("tx_drained", tx_exp.size(), 0);
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{op: 8'h10, len: 16'd12,    nw: 2,  base: 32'd3,        step: 32'd1,
                   rx: 32'h0000_0007};
        tbl[1] = '{op: 8'h11, len: 16'd4,     nw: 0,  base: 32'd0,        step: 32'd0,
                   rx: 32'h0000_000C};
        tbl[2] = '{op: 8'h12, len: 16'd10,    nw: 1,  base: 32'hAABBCCDD, step: 32'd0,
                   rx: 32'h1234_5678};
        tbl[3] = '{op: 8'h10, len: 16'd2,     nw: 0,  base: 32'd0,        step: 32'd0,
                   rx: 32'h8000_0001};
        tbl[4] = '{op: 8'h11, len: 16'h0103,  nw: 63, base: 32'h0102_0304, step: 32'h1111_1111,
                   rx: 32'hCAFE_BABE};

        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_len = '0;
        op_valid = 1'b0; op_data = '0; tx_ready = 1'b1;
        rx_valid = 1'b0; rx_data = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_op_ready", {31'd0, op_ready}, 0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("cmd_ready_after_rst", {31'd0, cmd_ready}, 1);

        for (int i = 0; i < 5; i++) run_pkt(tbl[i]);

        // tx_ready 0-1-0-1 around the header.
        v = '{op: 8'h12, len: 16'd8, nw: 1, base: 32'h1122_3344, step: 32'd0, rx: 32'd5};
        push_exp(v);
        tx_ready = 1'b0;
        send_cmd(v.op, v.len);
        repeat (2) begin
            @(negedge clk);
            chk("stall_op_byte", {24'd0, tx_data}, {24'd0, v.op});
        end
        @(posedge clk); #1; tx_ready = 1'b1;
        @(posedge clk); #1; tx_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stall_rsv_valid", {31'd0, tx_valid}, 1);
            chk("stall_rsv_byte", {24'd0, tx_data}, 0);
        end
        @(posedge clk); #1; tx_ready = 1'b1;
        send_op(v.base);
        send_rx_word(v.rx);
        take_rsp();
        chk("stall_drained", tx_exp.size(), 0);

        // len=7 with an operand offered: no operand accepted or sent.
        v = '{op: 8'h10, len: 16'd7, nw: 0, base: 32'd0, step: 32'd0, rx: 32'h0000_0042};
        op_valid = 1'b1; op_data = 32'hCAFE_F00D; op_seen = 1'b0;
        run_pkt(v);
        chk("len7_op_ready_never", {31'd0, op_seen}, 0);
        op_valid = 1'b0;

        // rx bytes offered in StOperand are ignored; response held while not taken.
        v = '{op: 8'h11, len: 16'd8, nw: 1, base: 32'h0102_0304, step: 32'd0, rx: 32'hDEADBEEF};
        push_exp(v);
        send_cmd(v.op, v.len);
        hdr_check(v.op, v.len);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 8'h55;
        repeat (3) begin
            @(negedge clk);
            chk("early_rx_ready", {31'd0, rx_ready}, 0);
        end
        @(posedge clk); #1; rx_valid = 1'b0;
        send_op(v.base);
        send_rx_word(v.rx);
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 1);
            chk("hold_rsp_data", rsp_data, 32'hDEADBEEF);
        end
        take_rsp();

        // Reset after the 2nd operand byte aborts the packet.
        v = '{op: 8'h10, len: 16'd12, nw: 2, base: 32'hA1B2_C3D4, step: 32'd1, rx: 32'd9};
        push_exp(v);
        send_cmd(v.op, v.len);
        hdr_check(v.op, v.len);
        send_op(v.base);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_tx_valid", {31'd0, tx_valid}, 0);
        chk("abort_tx_data", {24'd0, tx_data}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_cmd_ready", {31'd0, cmd_ready}, 0);
        chk("abort_op_ready", {31'd0, op_ready}, 0);
        chk("abort_rsp_data", rsp_data, 0);
        chk("abort_sent_two", tx_exp.size(), 6);
        tx_exp.delete();
        rsp_exp.delete();
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        @(posedge clk); #1;
        chk("cmd_ready_after_abort", {31'd0, cmd_ready}, 1);
        run_pkt(tbl[0]);

        repeat (5) @(posedge clk);
        chk("rsp_drained", rsp_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
